fp_round_pipe: RTL and testbench
================================

Name: fp_round_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-precision rounding stage of the FP adder datapath.
- Takes the normalised significand, guard and round bits, a sticky bit, sign and biased exponent, and produces the final packed exponent and fraction.
- Supports four rounding modes, IEEE overflow and special-value handling, a valid/ready handshake with full-pipeline stall, and sticky exception flags.
- Sits between the normaliser/shifter and the result register of the add/sub and mul units.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored fraction width (hidden bit excluded)
STAGES, 2, pipeline depth in registers, legal 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
in_sign  in  1  result sign
in_exp  in  EXP_W  biased exponent; 0 = subnormal, all-ones = inf/NaN
in_mantis  in  MAN_W+3  {hidden, fraction[MAN_W-1:0], guard, round}
in_sticky  in  1  OR of all bits shifted out below round
in_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_sign  out  1  result sign
out_exp  out  EXP_W  rounded exponent
out_mantis  out  MAN_W  rounded fraction
out_inexact  out  1  this beat lost precision
out_overflow  out  1  this beat overflowed
flags_clr  in  1  synchronous clear of accumulated flags
flags_acc  out  2  {overflow, inexact} sticky OR over all delivered beats

Behaviour:
- Reset (async, rst_n=0): all stage valids, out_valid, out_sign, out_exp, out_mantis, out_inexact, out_overflow and flags_acc go to 0; in_ready is 1 after reset release.
- Handshake:
  - A beat transfers when in_valid & in_ready (input) or out_valid & out_ready (output).
  - in_ready = ~out_valid | out_ready. The whole pipeline advances only when in_ready = 1; otherwise every stage holds.
  - Bubbles propagate as invalid stages.
  - Latency is exactly STAGES cycles from input transfer to out_valid with no stall. Order is preserved; no beat is dropped or duplicated.
- Round bits: L = in_mantis[2] (fraction LSB), G = in_mantis[1], R = in_mantis[0], S = in_sticky. Define X = R|S.
- Increment decision, inc:
  - RNE: G & (X | L).
  - RTZ: 0.
  - RUP: ~sign & (G|X).
  - RDN: sign & (G|X).
- Inexact: inexact = G|X.
- Significand: Q = in_mantis[MAN_W+2:2] + inc, computed MAN_W+2 bits wide; carry = Q[MAN_W+1].
  - carry=1: fraction = 0, exp = in_exp + 1.
  - carry=0, in_exp=0, Q[MAN_W]=1: subnormal promotes; exp = 1, fraction = Q[MAN_W-1:0].
  - Otherwise: exp = in_exp, fraction = Q[MAN_W-1:0].
- Overflow: triggered when the resulting exp reaches all-ones from a finite input. out_overflow = 1 and out_inexact = 1. Result by mode:
  - RNE: infinity (exp all-ones, fraction 0).
  - RTZ: max finite (exp all-ones-1, fraction all-ones).
  - RUP: infinity if positive, else max finite.
  - RDN: infinity if negative, else max finite.
- Special input (in_exp all-ones): exp and fraction in_mantis[MAN_W+1:2] pass through unrounded; inexact = overflow = 0.
- Sign always passes unchanged.
- Sticky flags:
  - flags_acc ORs in {out_overflow, out_inexact} on each output transfer.
  - flags_clr clears flags_acc the same cycle. If flags_clr coincides with a transfer, the transfer's flags are kept (clear then set).
- Arithmetic occurs in the first stage; remaining stages are pure delay registers.
- Reset asserted mid-operation discards all in-flight beats.

Test Plan:
1. RNE tie-to-even (EXP_W=8, MAN_W=23): exp=0x80, hidden=1, fraction=0x000002, G=1, R=0, S=0 -> exp 0x80, fraction 0x000002, inexact=1. Same with fraction=0x000003 -> fraction 0x000004.
2. Mantissa carry: exp=0x80, hidden=1, fraction=0x7FFFFF, G=1, RNE -> exp 0x81, fraction 0, inexact=1, overflow=0.
3. Overflow by mode: exp=0xFE, fraction=0x7FFFFF, G=1, sign=0.
   - RNE -> exp 0xFF, fraction 0, overflow=1.
   - RTZ -> exp 0xFE, fraction 0x7FFFFF, overflow=1.
   - RDN with sign=1 -> exp 0xFF, fraction 0.
4. Subnormal promote and special: exp=0, hidden=0, fraction=0x7FFFFF, G=1, RNE -> exp 0x01, fraction 0. Input exp=0xFF, fraction=0x400000, G=1 -> unchanged, flags 0.
5. Backpressure (STAGES=2): stream 6 beats with in_valid=1; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 throughout the stall, all 6 beats emerge in order, latency 2 with no stall.
6. Flags/reset: inexact beat sets flags_acc=01; flags_clr together with an overflow beat -> flags_acc=11. rst_n=0 with 2 beats in flight -> out_valid=0, flags_acc=0 immediately; no stale beat after release.

Source files
------------

// File: rtl/fp_round_if.sv
// Stream interface of the pipelined FP rounding stage: input beat, output beat
// and accumulated exception flags.
interface fp_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W+2:0] in_mantis;
  logic             in_sticky;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_mantis;
  logic             out_inexact;
  logic             out_overflow;
  logic             flags_clr;
  logic [1:0]       flags_acc;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mantis, in_sticky, in_mode,
    input  out_ready, flags_clr,
    output in_ready, out_valid, out_sign, out_exp, out_mantis,
    output out_inexact, out_overflow, flags_acc
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mantis, in_sticky, in_mode,
    output out_ready, flags_clr,
    input  in_ready, out_valid, out_sign, out_exp, out_mantis,
    input  out_inexact, out_overflow, flags_acc
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Pipelined IEEE rounding stage: rounds in the first register stage, then
// delays through STAGES-1 plain registers; whole pipe stalls on backpressure.
module fp_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  fp_round_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
    logic             inexact;
    logic             overflow;
  } stage_t;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

  stage_t           pipe_r [STAGES];
  stage_t           rnd_s;
  logic [1:0]       flags_r;
  logic             advance_s;
  logic             out_fire_s;
  logic             lsb_s, grd_s, rx_s;
  logic             inc_s, inc_rne_s, to_inf_s, special_s, sig_ones_s;
  logic [MAN_W:0]   sig_s;
  logic [MAN_W+1:0] q_s;

  assign advance_s  = ~pipe_r[STAGES-1].valid | bus.out_ready;
  assign out_fire_s = pipe_r[STAGES-1].valid & bus.out_ready;

  // Rounding decision and result selection for the incoming beat.
  always_comb begin
    lsb_s      = bus.in_mantis[2];
    grd_s      = bus.in_mantis[1];
    rx_s       = bus.in_mantis[0] | bus.in_sticky;
    inc_rne_s  = grd_s & (rx_s | lsb_s);
    case (bus.in_mode)
      2'b00:   inc_s = inc_rne_s;
      2'b01:   inc_s = 1'b0;
      2'b10:   inc_s = ~bus.in_sign & (grd_s | rx_s);
      2'b11:   inc_s = bus.in_sign & (grd_s | rx_s);
      default: inc_s = inc_rne_s;
    endcase
    sig_s      = bus.in_mantis[MAN_W+2:2];
    q_s        = {1'b0, sig_s} + {{(MAN_W+1){1'b0}}, inc_s};
    sig_ones_s = &sig_s;
    special_s  = (bus.in_exp == EXP_ONES);
    to_inf_s   = (bus.in_mode == 2'b00) |
                 ((bus.in_mode == 2'b10) & ~bus.in_sign) |
                 ((bus.in_mode == 2'b11) & bus.in_sign);

    rnd_s.valid    = bus.in_valid;
    rnd_s.sign     = bus.in_sign;
    rnd_s.exp      = bus.in_exp;
    rnd_s.frac     = q_s[MAN_W-1:0];
    rnd_s.inexact  = grd_s | rx_s;
    rnd_s.overflow = 1'b0;

    if (special_s) begin
      rnd_s.frac    = bus.in_mantis[MAN_W+1:2];
      rnd_s.inexact = 1'b0;
    end else if ((bus.in_exp == EXP_MAXF) && sig_ones_s && (inc_s | inc_rne_s)) begin
      // A carry out of the largest finite binade, either under the selected
      // mode or under nearest rounding, is an overflow; the mode picks the result.
      rnd_s.overflow = 1'b1;
      rnd_s.inexact  = 1'b1;
      if (to_inf_s) begin
        rnd_s.exp  = EXP_ONES;
        rnd_s.frac = {MAN_W{1'b0}};
      end else begin
        rnd_s.exp  = EXP_MAXF;
        rnd_s.frac = {MAN_W{1'b1}};
      end
    end else if (q_s[MAN_W+1]) begin
      rnd_s.exp  = bus.in_exp + EXP_ONE;
      rnd_s.frac = {MAN_W{1'b0}};
    end else if ((bus.in_exp == {EXP_W{1'b0}}) && q_s[MAN_W]) begin
      rnd_s.exp = EXP_ONE;
    end else begin
      rnd_s.exp = bus.in_exp;
    end
  end

  // Pipeline registers; every stage moves together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe_r[i] <= '0;
    end else if (advance_s) begin
      pipe_r[0] <= rnd_s;
      for (int i = 1; i < STAGES; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  // Sticky exception flags; a clear yields to the flags of a coincident transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 2'b00;
    end else if (bus.flags_clr) begin
      flags_r <= out_fire_s ? {pipe_r[STAGES-1].overflow, pipe_r[STAGES-1].inexact} : 2'b00;
    end else if (out_fire_s) begin
      flags_r <= flags_r | {pipe_r[STAGES-1].overflow, pipe_r[STAGES-1].inexact};
    end
  end

  assign bus.in_ready     = advance_s;
  assign bus.out_valid    = pipe_r[STAGES-1].valid;
  assign bus.out_sign     = pipe_r[STAGES-1].sign;
  assign bus.out_exp      = pipe_r[STAGES-1].exp;
  assign bus.out_mantis   = pipe_r[STAGES-1].frac;
  assign bus.out_inexact  = pipe_r[STAGES-1].inexact;
  assign bus.out_overflow = pipe_r[STAGES-1].overflow;
  assign bus.flags_acc    = flags_r;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe: directed vector table, stall/flag/reset
// sequences and a randomized stream checked by an arithmetic reference model.
module tb_fp_round_pipe;
  localparam int EW = 8;
  localparam int MW = 23;
  localparam int ST = 2;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] frac;
    logic          inx;
    logic          ov;
  } res_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW+2:0] mant;
    logic          sticky;
    logic [1:0]    mode;
    logic [EW-1:0] e_exp;
    logic [MW-1:0] e_frac;
    logic          e_inx;
    logic          e_ov;
  } dir_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_round_if #(.EXP_W(EW), .MAN_W(MW)) bus ();
  fp_round_pipe #(.EXP_W(EW), .MAN_W(MW), .STAGES(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_count = 0;
  res_t sb_q[$];
  logic [1:0] flags_model = 2'b00;
  dir_t tbl[17];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: rounding expressed as integer arithmetic on the significand.
  function automatic res_t model(input logic s, input logic [EW-1:0] e, input logic [MW+2:0] m,
                                 input logic st, input logic [1:0] md);
    res_t    r;
    longint  sig, nsig, full, hid;
    bit      g, x, up, rne_up, lost;
    int      ne, emax;
    emax = (1 << EW) - 1;
    full = longint'(1) << (MW + 1);
    hid  = longint'(1) << MW;
    sig  = longint'(m >> 2);
    g    = m[1];
    x    = m[0] | st;
    lost = g || x;
    rne_up = (g && x) || (g && !x && (sig % 2 == 1));
    case (md)
      2'd0: up = rne_up;
      2'd1: up = 1'b0;
      2'd2: up = lost && !s;
      default: up = lost && s;
    endcase
    r.sign = s;
    if (int'(e) == emax) begin
      r.exp = e; r.frac = m[MW+1:2]; r.inx = 1'b0; r.ov = 1'b0;
      return r;
    end
    r.inx = lost;
    r.ov  = 1'b0;
    nsig  = sig + longint'(up);
    ne    = int'(e);
    if (ne == emax - 1 && (sig + longint'(up) >= full || sig + longint'(rne_up) >= full)) begin
      r.ov = 1'b1; r.inx = 1'b1;
      if (md == 2'd0 || (md == 2'd2 && !s) || (md == 2'd3 && s)) begin
        r.exp = EW'(emax); r.frac = '0;
      end else begin
        r.exp = EW'(emax - 1); r.frac = '1;
      end
      return r;
    end
    if (nsig >= full) begin
      ne = ne + 1; nsig = nsig / 2;
    end else if (ne == 0 && nsig >= hid) begin
      ne = 1;
    end
    r.exp  = EW'(ne);
    r.frac = MW'(nsig % hid);
    return r;
  endfunction

  function automatic logic [MW+2:0] mk_mant(input logic h, input logic [MW-1:0] f, input logic g, input logic rr);
    return {h, f, g, rr};
  endfunction

  function automatic dir_t mk(input logic s, input logic [EW-1:0] e, input logic [MW+2:0] m, input logic st,
                              input logic [1:0] md, input logic [EW-1:0] ee, input logic [MW-1:0] ef,
                              input logic ei, input logic eo);
    dir_t d;
    d.sign = s; d.exp = e; d.mant = m; d.sticky = st; d.mode = md;
    d.e_exp = ee; d.e_frac = ef; d.e_inx = ei; d.e_ov = eo;
    return d;
  endfunction

  // Scoreboard: model every accepted beat, compare every delivered beat and the flags.
  always @(negedge clk) begin
    res_t e;
    logic [1:0] upd;
    logic fire;
    if (!rst_n) begin
      sb_q.delete();
      flags_model = 2'b00;
    end else begin
      chk("flags_acc", 64'(bus.flags_acc), 64'(flags_model));
      upd  = 2'b00;
      fire = bus.out_valid && bus.out_ready;
      if (fire) begin
        out_count++;
        if (sb_q.size() == 0) begin
          chk("spurious_beat", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("beat%0d", out_count),
              64'({bus.out_sign, bus.out_exp, bus.out_mantis, bus.out_inexact, bus.out_overflow}), 64'(e));
          upd = {e.ov, e.inx};
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mantis, bus.in_sticky, bus.in_mode));
      if (bus.flags_clr) flags_model = fire ? upd : 2'b00;
      else if (fire)     flags_model = flags_model | upd;
    end
  end

  task automatic drive(input dir_t d);
    bus.in_sign = d.sign; bus.in_exp = d.exp; bus.in_mantis = d.mant;
    bus.in_sticky = d.sticky; bus.in_mode = d.mode;
  endtask

  task automatic send_dir(input int idx);
    bit got;
    @(posedge clk); #1;
    drive(tbl[idx]); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) chk($sformatf("vec%0d_timeout", idx), 64'(0), 64'(1));
    else chk($sformatf("vec%0d", idx),
             64'({bus.out_exp, bus.out_mantis, bus.out_inexact, bus.out_overflow}),
             64'({tbl[idx].e_exp, tbl[idx].e_frac, tbl[idx].e_inx, tbl[idx].e_ov}));
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic wait_out_valid(input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) chk(name, 64'(0), 64'(1));
  endtask

  initial begin
    dir_t bp[6];
    int idx, t, fire0, first_out, cnt0, stale;
    bit stall;

    tbl[0]  = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000002, 1'b1, 1'b0), 1'b0, 2'd0, 8'h80, 23'h000002, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000003, 1'b1, 1'b0), 1'b0, 2'd0, 8'h80, 23'h000004, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd0, 8'h81, 23'h000000, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 8'hFE, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd0, 8'hFF, 23'h000000, 1'b1, 1'b1);
    tbl[4]  = mk(1'b0, 8'hFE, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1);
    tbl[5]  = mk(1'b1, 8'hFE, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd3, 8'hFF, 23'h000000, 1'b1, 1'b1);
    tbl[6]  = mk(1'b0, 8'hFE, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd2, 8'hFF, 23'h000000, 1'b1, 1'b1);
    tbl[7]  = mk(1'b1, 8'hFE, mk_mant(1'b1, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd2, 8'hFE, 23'h7FFFFF, 1'b1, 1'b1);
    tbl[8]  = mk(1'b0, 8'h00, mk_mant(1'b0, 23'h7FFFFF, 1'b1, 1'b0), 1'b0, 2'd0, 8'h01, 23'h000000, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 8'hFF, mk_mant(1'b1, 23'h400000, 1'b1, 1'b0), 1'b0, 2'd0, 8'hFF, 23'h400000, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000005, 1'b0, 1'b0), 1'b0, 2'd2, 8'h80, 23'h000005, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000005, 1'b0, 1'b0), 1'b1, 2'd2, 8'h80, 23'h000006, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000005, 1'b0, 1'b0), 1'b1, 2'd3, 8'h80, 23'h000005, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000005, 1'b1, 1'b1), 1'b0, 2'd1, 8'h80, 23'h000005, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000004, 1'b1, 1'b1), 1'b0, 2'd0, 8'h80, 23'h000005, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 8'h80, mk_mant(1'b1, 23'h000005, 1'b0, 1'b1), 1'b0, 2'd0, 8'h80, 23'h000005, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 8'h80, mk_mant(1'b1, 23'h000004, 1'b1, 1'b0), 1'b0, 2'd3, 8'h80, 23'h000005, 1'b1, 1'b0);

    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flags_clr = 1'b0;
    drive(tbl[0]);

    // Reset state, during and after reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_outputs", 64'({bus.out_sign, bus.out_exp, bus.out_mantis, bus.out_inexact, bus.out_overflow}), 64'(0));
    chk("rst_flags", 64'(bus.flags_acc), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 17; i++) send_dir(i);
    drain();

    // Backpressure: six beats, three-cycle output stall mid-stream.
    for (int i = 0; i < 6; i++)
      bp[i] = mk($urandom_range(0, 1), 8'h40 + 8'(i), mk_mant(1'b1, MW'($urandom), 1'($urandom), 1'($urandom)),
                 1'($urandom), 2'($urandom), 8'h00, 23'h0, 1'b0, 1'b0);
    cnt0 = out_count; idx = 0; t = 0; fire0 = -1; first_out = -1;
    while (idx < 6 && t < 40) begin
      @(posedge clk); #1;
      stall = (t >= 3 && t < 6);
      bus.out_ready = !stall;
      bus.in_valid  = 1'b1;
      drive(bp[idx]);
      @(negedge clk);
      if (stall) chk($sformatf("in_ready_stall_t%0d", t), 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && first_out < 0) first_out = cyc;
      if (bus.in_ready) begin
        if (idx == 0) fire0 = cyc;
        idx++;
      end
      t++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain();
    chk("bp_latency", 64'(first_out - fire0), 64'(ST));
    chk("bp_beat_count", 64'(out_count - cnt0), 64'(6));

    // Randomized stream with random backpressure and flag clears.
    for (int n = 0; n < 600; n++) begin
      logic [EW-1:0] e;
      logic [MW+2:0] m;
      @(posedge clk); #1;
      case ($urandom_range(0, 5))
        0: e = 8'h00;
        1: e = 8'hFE;
        2: e = 8'hFF;
        3: e = 8'h01;
        default: e = EW'($urandom);
      endcase
      m = (MW+3)'($urandom);
      if ($urandom_range(0, 3) == 0) m = {1'b1, {MW{1'b1}}, 2'($urandom)};
      else if (e != 8'h00) m[MW+2] = 1'b1;
      bus.in_sign = 1'($urandom); bus.in_exp = e; bus.in_mantis = m;
      bus.in_sticky = 1'($urandom); bus.in_mode = 2'($urandom);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flags_clr = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flags_clr = 1'b0;
    drain();

    // Flags: clear alone, inexact beat, clear coinciding with transfers.
    @(posedge clk); #1 bus.flags_clr = 1'b1;
    @(posedge clk); #1 bus.flags_clr = 1'b0;
    @(negedge clk);
    chk("flags_cleared", 64'(bus.flags_acc), 64'(0));
    send_dir(0);
    @(negedge clk);
    chk("flags_inexact", 64'(bus.flags_acc), 64'(2'b01));
    @(posedge clk); #1;
    bus.out_ready = 1'b0; drive(tbl[3]); bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_out_valid("ovf_stage_timeout");
    @(posedge clk); #1 bus.flags_clr = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.flags_clr = 1'b0;
    @(negedge clk);
    chk("flags_clr_ovf", 64'(bus.flags_acc), 64'(2'b11));
    @(posedge clk); #1;
    bus.out_ready = 1'b0; drive(tbl[0]); bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_out_valid("inx_stage_timeout");
    @(posedge clk); #1 bus.flags_clr = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.flags_clr = 1'b0;
    @(negedge clk);
    chk("flags_clr_inx", 64'(bus.flags_acc), 64'(2'b01));

    // Reset with two beats in flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b1; drive(tbl[0]); bus.in_valid = 1'b1;
    @(posedge clk); #1 drive(tbl[1]);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_flags", 64'(bus.flags_acc), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale_beat", 64'(stale), 64'(0));
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
